// File: rtl/sha256_block_feeder.sv
// sha256_block_feeder
// Upstream stage of the SHA-256 compression core. On start it reads
// NUM_OF_WORDS 32-bit message words from word-addressed memory, appends the
// standard SHA-256 padding (0x80000000 marker, zero fill, 64-bit bit length)
// and hands the result to the core one 512-bit block at a time.
//
// Ports:
//   clk, reset      single clock, synchronous active-high reset
//   start           begin a message (only looked at while idle)
//   message_addr    word address of message word 0, latched on start
//   mem_clk/mem_we  memory clock (same as clk) and write enable (always 0)
//   mem_addr        registered read address
//   mem_read_data   read data for the address registered on the previous edge
//   block_data      padded block, word k in bits [511-32k : 480-32k]
//   block_valid/ready, block_last, block_idx   block handshake and tags
//   busy, done      activity flag and one-cycle end-of-message pulse
module sha256_block_feeder #(
    parameter int NUM_OF_WORDS = 20
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [15:0]  message_addr,
    output logic         mem_clk,
    output logic         mem_we,
    output logic [15:0]  mem_addr,
    input  logic [31:0]  mem_read_data,
    output logic [511:0] block_data,
    output logic         block_valid,
    input  logic         block_ready,
    output logic         block_last,
    output logic [7:0]   block_idx,
    output logic         busy,
    output logic         done
);

    localparam int          NUM_BLOCKS = (NUM_OF_WORDS + 2) / 16 + 1;
    localparam logic [15:0] MSG_WORDS  = 16'(NUM_OF_WORDS);
    localparam logic [7:0]  LAST_BLOCK = 8'(NUM_BLOCKS - 1);
    localparam logic [31:0] BIT_LEN    = 32'(NUM_OF_WORDS * 32);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_FILL    = 2'd1;
    localparam logic [1:0] S_PRESENT = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    logic [1:0]  state;
    logic [15:0] base_addr;
    logic [7:0]  blk;
    logic [4:0]  k;

    logic [15:0] blk_offset;
    logic [3:0]  word_sel;
    logic [15:0] global_idx;
    logic        is_last;
    logic [31:0] next_word;

    assign mem_clk   = clk;
    assign mem_we    = 1'b0;
    assign block_idx = blk;
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);

    // The word captured at step k is word k-1 of the block; at k=16 the 4-bit
    // subtraction wraps to 15, which is exactly the last word.
    always_comb begin
        blk_offset = {4'b0, blk, 4'b0};
        word_sel   = k[3:0] - 4'd1;
        global_idx = blk_offset + {12'b0, word_sel};
        is_last    = (blk == LAST_BLOCK);
        next_word  = 32'h0;
        if (global_idx < MSG_WORDS) begin
            next_word = mem_read_data;
        end else if (global_idx == MSG_WORDS) begin
            next_word = 32'h8000_0000;
        end else if (is_last && (word_sel == 4'd15)) begin
            next_word = BIT_LEN;
        end
    end

    // Main sequencer. FILL issues addresses for steps 0..15 and captures the
    // word addressed on the previous step for steps 1..16. PRESENT spends its
    // first cycle raising block_valid, then waits for the transfer. The
    // memory is still addressed for padding words; that data is ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            base_addr   <= 16'h0;
            blk         <= 8'h0;
            k           <= 5'h0;
            mem_addr    <= 16'h0;
            block_data  <= '0;
            block_valid <= 1'b0;
            block_last  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        base_addr <= message_addr;
                        blk       <= 8'h0;
                        k         <= 5'h0;
                        state     <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (k < 5'd16) begin
                        mem_addr <= base_addr + blk_offset + {11'b0, k};
                    end
                    if (k != 5'd0) begin
                        for (int i = 0; i < 16; i++) begin
                            if (word_sel == 4'(i)) begin
                                block_data[511 - 32*i -: 32] <= next_word;
                            end
                        end
                    end
                    if (k == 5'd16) begin
                        state <= S_PRESENT;
                    end else begin
                        k <= k + 5'd1;
                    end
                end
                S_PRESENT: begin
                    if (!block_valid) begin
                        block_valid <= 1'b1;
                        block_last  <= is_last;
                    end else if (block_ready) begin
                        block_valid <= 1'b0;
                        block_last  <= 1'b0;
                        if (is_last) begin
                            state <= S_DONE;
                        end else begin
                            blk   <= blk + 8'd1;
                            k     <= 5'h0;
                            state <= S_FILL;
                        end
                    end
                end
                default: begin
                    blk   <= 8'h0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_block_feeder.sv
// tb_sha256_block_feeder
// Directed bench for sha256_block_feeder. Four instances with message lengths
// 20, 13, 14 and 16 words share one clock, reset, block_ready and a single
// word memory holding mem[0x100+i] = i+1. Expected blocks are written out by
// hand below.
module tb_sha256_block_feeder;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   start;
    logic [15:0]  message_addr;
    logic         block_ready;

    logic [3:0]   mclk;
    logic [3:0]   mwe;
    logic [15:0]  maddr [4];
    logic [31:0]  rdata [4];
    logic [511:0] bdata [4];
    logic [3:0]   bvalid;
    logic [3:0]   blast;
    logic [7:0]   bidx [4];
    logic [3:0]   busy;
    logic [3:0]   done;

    logic [31:0]  mem [0:65535];

    int compared   = 0;
    int mismatched = 0;

    int           nblocks [4] = '{2, 1, 2, 2};
    logic [511:0] exp_blk [4][2];

    localparam logic [511:0] EXP20_0 = {32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8,
                                        32'd9, 32'd10, 32'd11, 32'd12, 32'd13, 32'd14, 32'd15, 32'd16};
    localparam logic [511:0] EXP20_1 = {32'd17, 32'd18, 32'd19, 32'd20, 32'h80000000, 288'd0,
                                        32'h0, 32'h280};
    localparam logic [511:0] EXP13_0 = {32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8,
                                        32'd9, 32'd10, 32'd11, 32'd12, 32'd13, 32'h80000000,
                                        32'h0, 32'h1A0};
    localparam logic [511:0] EXP14_0 = {32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8,
                                        32'd9, 32'd10, 32'd11, 32'd12, 32'd13, 32'd14,
                                        32'h80000000, 32'h0};
    localparam logic [511:0] EXP14_1 = {480'd0, 32'h1C0};
    localparam logic [511:0] EXP16_1 = {32'h80000000, 448'd0, 32'h200};

    always #5 clk = ~clk;

    for (genvar i = 0; i < 4; i++) begin : g_dut
        sha256_block_feeder #(
            .NUM_OF_WORDS(i == 0 ? 20 : (i == 1 ? 13 : (i == 2 ? 14 : 16)))
        ) u_dut (
            .clk          (clk),
            .reset        (reset),
            .start        (start[i]),
            .message_addr (message_addr),
            .mem_clk      (mclk[i]),
            .mem_we       (mwe[i]),
            .mem_addr     (maddr[i]),
            .mem_read_data(rdata[i]),
            .block_data   (bdata[i]),
            .block_valid  (bvalid[i]),
            .block_ready  (block_ready),
            .block_last   (blast[i]),
            .block_idx    (bidx[i]),
            .busy         (busy[i]),
            .done         (done[i])
        );
        assign rdata[i] = mem[maddr[i]];
    end

    // Reset is held for two edges; every instance must come up idle and clear.
    task automatic test_reset();
        reset        = 1'b1;
        start        = 4'b0;
        block_ready  = 1'b1;
        message_addr = 16'h0100;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            compared++;
            if (busy[i] !== 1'b0 || bvalid[i] !== 1'b0 || blast[i] !== 1'b0 || done[i] !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL reset_flags dut%0d: busy=%b valid=%b last=%b done=%b, required all 0",
                         i, busy[i], bvalid[i], blast[i], done[i]);
            end
            compared++;
            if (maddr[i] !== 16'h0 || bidx[i] !== 8'h0 || bdata[i] !== 512'h0) begin
                mismatched++;
                $display("[TB] FAIL reset_regs dut%0d: addr=%h idx=%h data=%h, required zeros",
                         i, maddr[i], bidx[i], bdata[i]);
            end
            compared++;
            if (mwe[i] !== 1'b0 || mclk[i] !== clk) begin
                mismatched++;
                $display("[TB] FAIL mem_ctrl dut%0d: we=%b mem_clk=%b, required we=0 mem_clk=%b",
                         i, mwe[i], mclk[i], clk);
            end
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Full message with block_ready held high: latency, block contents, tags
    // and the single done pulse after the final transfer.
    task automatic test_message(input int sel);
        int cnt;
        block_ready = 1'b1;
        start[sel]  = 1'b1;
        @(posedge clk);
        #1;
        start[sel] = 1'b0;
        for (int blk = 0; blk < nblocks[sel]; blk++) begin
            cnt = 0;
            while (bvalid[sel] !== 1'b1 && cnt < 60) begin
                @(posedge clk);
                #1;
                cnt++;
            end
            compared++;
            if (cnt != 18) begin
                mismatched++;
                $display("[TB] FAIL latency dut%0d blk%0d: %0d edges, required 18", sel, blk, cnt);
            end
            compared++;
            if (bidx[sel] !== 8'(blk) || blast[sel] !== (blk == nblocks[sel] - 1)) begin
                mismatched++;
                $display("[TB] FAIL tags dut%0d blk%0d: idx=%0d last=%b, required idx=%0d last=%b",
                         sel, blk, bidx[sel], blast[sel], blk, (blk == nblocks[sel] - 1));
            end
            compared++;
            if (bdata[sel] !== exp_blk[sel][blk]) begin
                mismatched++;
                $display("[TB] FAIL data dut%0d blk%0d: got %h required %h",
                         sel, blk, bdata[sel], exp_blk[sel][blk]);
            end
            @(posedge clk);
            #1;
            compared++;
            if (bvalid[sel] !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL valid_drop dut%0d blk%0d: valid=%b, required 0", sel, blk, bvalid[sel]);
            end
            compared++;
            if (done[sel] !== (blk == nblocks[sel] - 1)) begin
                mismatched++;
                $display("[TB] FAIL done_pulse dut%0d blk%0d: done=%b, required %b",
                         sel, blk, done[sel], (blk == nblocks[sel] - 1));
            end
        end
        @(posedge clk);
        #1;
        compared++;
        if (done[sel] !== 1'b0 || busy[sel] !== 1'b0 || bidx[sel] !== 8'h0) begin
            mismatched++;
            $display("[TB] FAIL after_done dut%0d: done=%b busy=%b idx=%0d, required 0/0/0",
                     sel, done[sel], busy[sel], bidx[sel]);
        end
    endtask

    // Block 0 is stalled for 10 cycles with a stray start in the middle; the
    // block and the address must not move and the extra start is not queued.
    task automatic test_backpressure();
        int           cnt;
        logic [511:0] held_data;
        logic [15:0]  held_addr;
        block_ready = 1'b0;
        start[0]    = 1'b1;
        @(posedge clk);
        #1;
        start[0] = 1'b0;
        cnt = 0;
        while (bvalid[0] !== 1'b1 && cnt < 60) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        compared++;
        if (bvalid[0] !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL bp_wait: valid=%b after %0d edges, required 1", bvalid[0], cnt);
        end
        held_data = bdata[0];
        held_addr = maddr[0];
        for (int c = 0; c < 10; c++) begin
            start[0] = (c == 3);
            @(posedge clk);
            #1;
            compared++;
            if (bvalid[0] !== 1'b1 || bidx[0] !== 8'h0 || bdata[0] !== held_data || maddr[0] !== held_addr) begin
                mismatched++;
                $display("[TB] FAIL bp_hold cycle%0d: valid=%b idx=%0d addr=%h, required 1/0/%h with data held",
                         c, bvalid[0], bidx[0], maddr[0], held_addr);
            end
        end
        start[0] = 1'b0;
        compared++;
        if (held_data !== EXP20_0) begin
            mismatched++;
            $display("[TB] FAIL bp_data: got %h required %h", held_data, EXP20_0);
        end
        block_ready = 1'b1;
        @(posedge clk);
        #1;
        cnt = 0;
        while (bvalid[0] !== 1'b1 && cnt < 60) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        compared++;
        if (cnt != 18 || bidx[0] !== 8'd1 || blast[0] !== 1'b1 || bdata[0] !== EXP20_1) begin
            mismatched++;
            $display("[TB] FAIL bp_blk1: lat=%0d idx=%0d last=%b data=%h, required 18/1/1/%h",
                     cnt, bidx[0], blast[0], bdata[0], EXP20_1);
        end
        @(posedge clk);
        #1;
        compared++;
        if (done[0] !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL bp_done: done=%b, required 1", done[0]);
        end
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            compared++;
            if (busy[0] !== 1'b0 || done[0] !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL bp_idle cycle%0d: busy=%b done=%b, required 0/0", c, busy[0], done[0]);
            end
        end
    endtask

    // Reset lands in the middle of the first fill; the message is dropped
    // silently and a fresh start must produce the whole message again.
    task automatic test_reset_mid_fill();
        block_ready = 1'b1;
        start[0]    = 1'b1;
        @(posedge clk);
        #1;
        start[0] = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        compared++;
        if (busy[0] !== 1'b1 || maddr[0] === 16'h0) begin
            mismatched++;
            $display("[TB] FAIL mid_fill_pre: busy=%b addr=%h, required busy=1 addr nonzero", busy[0], maddr[0]);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        compared++;
        if (busy[0] !== 1'b0 || bvalid[0] !== 1'b0 || done[0] !== 1'b0 || maddr[0] !== 16'h0) begin
            mismatched++;
            $display("[TB] FAIL mid_fill_reset: busy=%b valid=%b done=%b addr=%h, required 0/0/0/0000",
                     busy[0], bvalid[0], done[0], maddr[0]);
        end
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            compared++;
            if (done[0] !== 1'b0 || busy[0] !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL mid_fill_quiet cycle%0d: done=%b busy=%b, required 0/0", c, done[0], busy[0]);
            end
        end
        test_message(0);
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) mem[a] = 32'h0;
        for (int i = 0; i < 32; i++) mem[16'h0100 + i] = 32'(i + 1);
        exp_blk[0][0] = EXP20_0;
        exp_blk[0][1] = EXP20_1;
        exp_blk[1][0] = EXP13_0;
        exp_blk[1][1] = 512'h0;
        exp_blk[2][0] = EXP14_0;
        exp_blk[2][1] = EXP14_1;
        exp_blk[3][0] = EXP20_0;
        exp_blk[3][1] = EXP16_1;

        test_reset();
        test_message(0);
        test_message(1);
        test_message(2);
        test_message(3);
        test_backpressure();
        test_reset_mid_fill();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/sha256_block_feeder.md
Name: sha256_block_feeder

Overview:
- Upstream stage of the SHA-256 compression core.
- On start, reads NUM_OF_WORDS 32-bit message words from word-addressed memory and appends standard SHA-256 padding: a 0x80000000 word, zero fill, and a 64-bit bit-length.
- Presents the result one 512-bit block at a time on a valid/ready interface. The core consumes block_data as w[0..15].
- Single-buffered: the next block is fetched only after the current block is accepted.

Parameters:
- NUM_OF_WORDS, 20: message length in 32-bit words. Legal range 1..2000.

Ports:
- clk  input  1  Single clock; all state updates on its rising edge.
- reset  input  1  Synchronous, active-high reset.
- start  input  1  Begin a message; sampled only in IDLE.
- message_addr  input  16  Word address of message word 0; latched when start is accepted.
- mem_clk  output  1  Equal to clk.
- mem_we  output  1  Constant 0; this block only reads.
- mem_addr  output  16  Read address (registered).
- mem_read_data  input  32  Data for the address presented the previous cycle.
- block_data  output  512  Padded block; word k in bits [511-32k : 480-32k].
- block_valid  output  1  block_data, block_idx and block_last are valid.
- block_ready  input  1  Consumer accepts the block.
- block_last  output  1  Current block is the final block.
- block_idx  output  8  Zero-based block number.
- busy  output  1  High in every state except IDLE.
- done  output  1  One-cycle pulse after the last block is accepted.

Behaviour:

Configuration:
- num_blocks = floor((NUM_OF_WORDS+2)/16)+1, computed at elaboration.
- Bit length L = NUM_OF_WORDS*32, emitted as a 64-bit big-endian value in words 14 and 15 of the last block. Word 14 is always 0 in the legal range.

Reset:
- While reset is high at a rising edge: state=IDLE, block_valid=0, block_last=0, block_idx=0, done=0, mem_addr=0, block_data=0, internal counters=0.
- Reset applies in any state, including mid-fill. The previous message is abandoned and no done pulse is produced.

States and transitions:
- IDLE: when start=1, latch message_addr, set b=0, k=0, go to FILL. start is ignored in all other states.
- FILL: runs exactly 17 cycles per block, k=0..16.
  - For k<16: mem_addr <= message_addr + 16b + k.
  - For k>=1: capture block word k-1 from global index g = 16b + (k-1):
    - g < NUM_OF_WORDS: mem_read_data.
    - g == NUM_OF_WORDS: 32'h80000000.
    - last block and (k-1)==15: L.
    - otherwise: 0.
  - Memory is still addressed for padding words; the returned data is discarded.
  - After capture at k=16, go to PRESENT.
- PRESENT: block_valid=1. block_data, block_idx=b and block_last=(b==num_blocks-1) are held stable until block_ready=1 at a rising edge (the transfer).
  - On transfer: block_valid <= 0.
  - If last block: go to DONE.
  - Else: b <= b+1, k <= 0, go to FILL.
  - block_ready while block_valid=0 is ignored.
- DONE: done=1 for exactly one cycle, then IDLE. block_idx returns to 0.

Latency:
- The first block_valid rises 18 rising edges after the edge that accepts start.
- Each later block rises 18 edges after the previous transfer edge.
- Minimum total = 18*num_blocks + num_blocks + 1 cycles.

Arithmetic:
- Address adds wrap modulo 2^16.
- block_idx is 8 bits; num_blocks <= 126 in the legal range.

Test Plan:
- NUM_OF_WORDS=20, mem[0x100+i]=i+1, block_ready=1 -> 2 blocks.
  - Block 0 = words 1..16, block_last=0.
  - Block 1 = 17,18,19,20, 0x80000000, nine zeros, 0x00000000, 0x00000280, block_last=1.
  - done pulses once, 1 cycle after the block 1 transfer.
- NUM_OF_WORDS=13 -> 1 block: words 0..12 = data, w13=0x80000000, w14=0, w15=0x000001A0, block_last=1.
- NUM_OF_WORDS=14 -> 2 blocks.
  - Block 0: w14=0x80000000, w15=0.
  - Block 1: all zero except w15=0x000001C0.
- NUM_OF_WORDS=16 -> block 1 w0=0x80000000, w15=0x00000200; no memory data appears in block 1.
- Backpressure: hold block_ready=0 for 10 cycles while block_valid=1 -> block_data/block_idx stable, no new mem_addr sequence; a second start pulse while busy is ignored.
- Assert reset during FILL of block 0 (cycle 7) -> next edge busy=0, block_valid=0, done=0, mem_addr=0; a fresh start then yields the correct blocks from the beginning.
